// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
`timescale 1ns/1ps
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Width of the latency down-counter (LATENCY range 0..15).
  localparam int LAT_W = 4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the memory stage and the responder.
//
// Handshake: each channel transfers at a rising clk edge where valid && ready.
// A source holds its payload stable while valid is high and ready is low;
// ready carries no meaning while valid is low.
`timescale 1ns/1ps
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_byte_array.sv
// Little-endian byte store: 4-byte synchronous write, combinational 32-bit
// read, byte indices wrap modulo 2**ADDR_BITS. The array is a plain unpacked
// variable named mem so an init flow can preload it hierarchically.
`timescale 1ns/1ps
module dmem_byte_array #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0] mem [DEPTH];

  // Commit all four bytes, least significant byte at the lowest address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        mem[waddr + ADDR_BITS'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  // Assemble the little-endian word starting at raddr.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < 4; k++) begin
      rdata[8*k +: 8] = mem[raddr + ADDR_BITS'(k)];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Responder end of the data-memory bus: accepts one word request at a time,
// waits LATENCY extra cycles, then presents a held response.
`timescale 1ns/1ps
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output state_t            state_dbg
);
  state_t               state_q, state_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_resp_q, err_resp_d;
  logic                 wr_q;
  logic                 err_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] acc_addr;
  logic                 accept;
  logic                 acc_err;
  logic [31:0]          mem_rdata;
  logic                 unused_addr_hi;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_resp_q;
  assign state_dbg      = state_q;

  // Address bits above the decoded range alias onto the same storage.
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_BITS];

  assign accept   = bus.req_valid && bus.req_ready && !reset;
  assign acc_err  = is_misaligned(bus.req_addr);
  assign acc_addr = {bus.req_addr[ADDR_BITS-1:2], 2'b00};

  // Writes commit at the acceptance edge, so a later reset cannot undo them.
  dmem_byte_array #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .we    (accept && bus.req_write && !acc_err),
    .waddr (acc_addr),
    .wdata (bus.req_wdata),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

  // Next state, counter and response payload. Every accepted request spends
  // LATENCY+1 cycles in WAIT, so the response rises LATENCY+1 edges after
  // acceptance (one edge when LATENCY is 0).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_resp_d = err_resp_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = WAIT;
          cnt_d   = LAT_W'(LATENCY);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          rdata_d    = (wr_q || err_q) ? 32'h0 : mem_rdata;
          err_resp_d = err_q;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any pending request or response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_resp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_resp_q <= err_resp_d;
    end
  end

  // Capture the request attributes needed to form the response.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q   <= bus.req_write;
      err_q  <= acc_err;
      addr_q <= acc_addr;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 3), a vector
// table, hand-written corner sequences and a randomized run against a
// byte-array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int NDUT = 3;
  localparam int MEM_BYTES = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [NDUT];
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_write  [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        resp_valid [NDUT];
  logic        resp_ready [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];
  state_t      st_dbg     [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_write  = req_write[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_rdata[g]  = bus.resp_rdata;
    assign resp_err[g]    = bus.resp_err;

    dmem_responder #(
      .ADDR_BITS (10),
      .LATENCY   (g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .bus       (bus),
      .state_dbg (st_dbg[g])
    );
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mdl [MEM_BYTES];

  // Spec rules: misaligned -> err, no change; write -> store bytes LE; read -> LE word.
  function automatic logic [32:0] model_access(input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int base;
    base = int'(a[9:0]);
    if (a[1:0] != 2'b00) return {1'b1, 32'h0};
    if (wr) begin
      for (int k = 0; k < 4; k++) mdl[(base + k) % MEM_BYTES] = wd[8*k +: 8];
      return {1'b0, 32'h0};
    end
    return {1'b0, mdl[(base + 3) % MEM_BYTES], mdl[(base + 2) % MEM_BYTES],
            mdl[(base + 1) % MEM_BYTES], mdl[base]};
  endfunction

  function automatic int exp_lat(input int d);
    return (d == 0 ? 2 : (d == 1 ? 0 : 3)) + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called and returns at #1 after a rising edge. lat = edges from the
  // acceptance edge until resp_valid is seen; rdy = req_ready after consume.
  task automatic do_req(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat, output logic rdy);
    int n;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 64) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    lat = 0;
    while (!resp_valid[d] && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata[d];
    er = resp_err[d];
    @(posedge clk); #1;
    rdy = req_ready[d];
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin : watchdog
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : main
    logic [31:0] rd, rd0, a, wd;
    logic        er, rdy;
    logic [32:0] e;
    int          lat, seen;
    bit          wr;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0011, 32'h5555_5555, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_03FC, 32'h1122_3344, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0000_07FC, 32'h0,         32'h1122_3344, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_F3FC, 32'h0,         32'h1122_3344, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0800, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};

    for (int d = 0; d < NDUT; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;

    // Reset state on every instance.
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_req_ready[%0d]", d), 32'(req_ready[d]), 32'h1);
      check($sformatf("rst_resp_valid[%0d]", d), 32'(resp_valid[d]), 32'h0);
      check($sformatf("rst_resp_rdata[%0d]", d), resp_rdata[d], 32'h0);
      check($sformatf("rst_resp_err[%0d]", d), 32'(resp_err[d]), 32'h0);
    end

    // Table-driven vectors on the LATENCY=2 instance.
    for (int i = 0; i < 11; i++) begin
      do_req(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat, rdy);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(0)));
      check($sformatf("vec%0d_ready_after", i), 32'(rdy), 32'h1);
    end

    // Little-endian byte placement of 0xDEADBEEF at 0x10.
    check("byte_0x10", 32'(g_dut[0].u_dut.u_mem.mem[16]), 32'hEF);
    check("byte_0x11", 32'(g_dut[0].u_dut.u_mem.mem[17]), 32'hBE);
    check("byte_0x12", 32'(g_dut[0].u_dut.u_mem.mem[18]), 32'hAD);
    check("byte_0x13", 32'(g_dut[0].u_dut.u_mem.mem[19]), 32'hDE);

    // Response backpressure: hold resp_ready low for 5 cycles.
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h3FC;
    seen = 0;
    while (!req_ready[0] && seen < 64) begin @(posedge clk); #1; seen++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    seen = 0;
    while (!resp_valid[0] && seen < 64) begin @(posedge clk); #1; seen++; end
    check("bp_first_rdata", resp_rdata[0], 32'h1122_3344);
    rd0 = 32'h1122_3344;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_c%0d", c), 32'(resp_valid[0]), 32'h1);
      check($sformatf("bp_rdata_c%0d", c), resp_rdata[0], rd0);
      check($sformatf("bp_req_ready_c%0d", c), 32'(req_ready[0]), 32'h0);
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 32'(req_ready[0]), 32'h1);
    check("bp_release_valid", 32'(resp_valid[0]), 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0, rd, er, lat, rdy);
    check("bp_second_not_taken", rd, 32'hDEAD_BEEF);

    // LATENCY=0 instance: response one edge after acceptance.
    do_req(1, 1'b1, 32'h20, 32'h0123_4567, rd, er, lat, rdy);
    check("lat0_write_latency", 32'(lat), 32'(exp_lat(1)));
    do_req(1, 1'b0, 32'h20, 32'h0, rd, er, lat, rdy);
    check("lat0_read_latency", 32'(lat), 32'(exp_lat(1)));
    check("lat0_read_rdata", rd, 32'h0123_4567);

    // LATENCY=3 instance: reset while in WAIT.
    do_req(2, 1'b1, 32'h40, 32'hA5A5_5A5A, rd, er, lat, rdy);
    check("lat3_write_latency", 32'(lat), 32'(exp_lat(2)));
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h44; req_wdata[2] = 32'h0BAD_C0DE;
    seen = 0;
    while (!req_ready[2] && seen < 64) begin @(posedge clk); #1; seen++; end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("midwait_in_wait", 32'(st_dbg[2]), 32'(WAIT));
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    check("midwait_req_ready", 32'(req_ready[2]), 32'h1);
    check("midwait_resp_valid", 32'(resp_valid[2]), 32'h0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (resp_valid[2]) seen++;
    end
    check("midwait_no_response", 32'(seen), 32'h0);
    do_req(2, 1'b0, 32'h40, 32'h0, rd, er, lat, rdy);
    check("midwait_old_write", rd, 32'hA5A5_5A5A);
    do_req(2, 1'b0, 32'h44, 32'h0, rd, er, lat, rdy);
    check("midwait_accepted_write", rd, 32'h0BAD_C0DE);

    // Randomized run on the LATENCY=2 instance against the model.
    for (int w = 0; w < 64; w++) begin
      a  = 32'h100 + 32'(w * 4);
      wd = $urandom;
      e  = model_access(1'b1, a, wd);
      do_req(0, 1'b1, a, wd, rd, er, lat, rdy);
    end
    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'hFFFF_FC00) | (32'h100 + 32'($urandom_range(0, 63) * 4));
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom;
      exp_q.push_back(model_access(wr, a, wd));
      do_req(0, wr, a, wd, rd, er, lat, rdy);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_rdata a=%h", i, a), rd, e[31:0]);
      check($sformatf("rnd%0d_err a=%h", i, a), 32'(er), 32'(e[32]));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat(0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
